packet_demux: RTL and testbench
===============================

# packet_demux

Receive-side counterpart of the HDMI packet transmit logic. It accepts fully assembled data-island packets (24-bit header plus four 56-bit subpackets, BCH already checked upstream) and dispatches them by packet type. Audio Sample packets are unpacked into a stereo sample stream with a valid/ready handshake. ACR N/CTS values and InfoFrame fields are captured into registers, and InfoFrame presence is tracked per video field. The block sits between the data-island deserializer/ECC stage and the audio output path in the pixel clock domain.

## Interface
Parameters:
- AUDIO_BIT_WIDTH, default 16: output sample width. Legal range 16..24.
- FIFO_DEPTH, default 8: audio FIFO depth in stereo pairs. Must be a power of two, ≥4.

Ports:
- clk_pixel  in  1  pixel clock.
- reset  in  1  synchronous, active-high.
- packet_valid  in  1  one-cycle strobe; header/sub are valid this cycle.
- packet_error  in  1  upstream uncorrectable BCH error, qualified by packet_valid.
- header  in  24  {HB2, HB1, HB0}.
- sub  in  4×56  subpackets; byte k of a subpacket is bits [8k+7:8k].
- video_field_end  in  1  one-cycle strobe per field.
- audio_valid  out  1  FIFO not empty.
- audio_ready  in  1  consumer accepts the head sample.
- audio_sample_word  out  2×AUDIO_BIT_WIDTH  [0]=left, [1]=right.
- acr_n, acr_cts  out  20 each  last received ACR values.
- acr_update  out  1  one-cycle pulse when new ACR values are loaded.
- vic  out  7  VIC from the last accepted AVI InfoFrame.
- infoframe_missing  out  3  bits {SPD, AVI, Audio}.
- audio_overflow  out  1  sticky; a sample was dropped because the FIFO was full.
- drop_count  out  8  saturating count of dropped packets.

## Operation
- States: IDLE, DECODE, AUDIO, CHECK, COMMIT.
  - IDLE: on packet_valid, register header/sub → DECODE. If packet_error is set, count a drop and stay in IDLE.
  - packet_valid while not in IDLE: the packet is dropped, drop_count increments, state is unaffected.
- DECODE, switched on HB0:
  - 0x00 (Null): → IDLE.
  - 0x01 (ACR): CTS={sub0[11:8],sub0[23:16],sub0[31:24]}, N={sub0[35:32],sub0[47:40],sub0[55:48]}. Load both, pulse acr_update → IDLE.
  - 0x02 (Audio Sample): if HB1[4]=1 (layout 1), drop and count. Otherwise → AUDIO.
  - 0x82, 0x83, 0x84: → CHECK.
  - Any other type: → IDLE, silently ignored.
- AUDIO: visits subpackets 0..3, one per cycle. For each i with HB1[i]=1, push left=sub_i[23:24-W] and right=sub_i[47:48-W]. If the FIFO is full, discard the sample and set audio_overflow. After subpacket 3 → IDLE.
- CHECK: one subpacket per cycle. Accumulates an 8-bit sum of HB0..HB2 plus PB0..PB[HB2[4:0]], where subpacket j holds PB7j..PB7j+6.
  - After 4 cycles: sum==0 → COMMIT. Otherwise drop and count → IDLE.
- COMMIT:
  - AVI (0x82): vic=sub0[38:32].
  - For all three InfoFrames: clear the field counter for that type → IDLE.
- Presence tracking: each InfoFrame type has a 2-bit saturating field counter that increments on video_field_end. infoframe_missing[k]=1 when counter[k]≥2.
  - If video_field_end and COMMIT hit the same type in the same cycle, the clear wins.
- FIFO: standard first-word-fall-through. A push and a pop in the same cycle while full is allowed and succeeds.
- drop_count saturates at 255.

## Timing
- Reset values: audio_valid=0, audio_sample_word=0, acr_n=0, acr_cts=0, acr_update=0, vic=0, infoframe_missing=3'b111, audio_overflow=0, drop_count=0, FSM=IDLE, FIFO empty, field counters=2.
- Reset mid-packet aborts processing with no partial commit.
- Latency, packet_valid at cycle t:
  - ACR: registers and acr_update at t+2.
  - Audio: first push at t+2, reaches audio_valid at t+3; last push at t+5.
  - InfoFrame commit at t+6 with checksum enabled, t+2 without.
- Worst-case occupancy is 6 cycles, well under the 32-cycle minimum packet spacing.

## Configuration
- PACKET_DEMUX_CHECKSUM_EN defined: CHECK state present; checksum failures are dropped and counted.
- Undefined: DECODE goes directly to COMMIT for InfoFrames; no checksum logic is synthesized.

## Structure
- Package hdmi_rx_pkg holds:
  - packet type constants (PKT_NULL, PKT_ACR, PKT_AUDIO, PKT_AVI, PKT_SPD, PKT_AIF);
  - the FSM state enum;
  - the stereo-sample typedef.
- Sub-module audio_sample_fifo holds the parameterized FWFT FIFO with full/empty flags.

## Test plan
- ACR: sub0 bytes 01,00,18,00,00,18,00 → acr_cts=0x01800, acr_n=0x01800, acr_update one pulse at t+2.
- Audio: HB1=0x0F, left 0x123456/right 0xABCDEF in every subpacket, W=16, audio_ready=1 → four pairs 0x1234/0xABCD on consecutive cycles.
- Overflow: FIFO_DEPTH=4, audio_ready=0, two full audio packets → 4 pairs held, audio_overflow=1; releasing audio_ready then delivers exactly 4 pairs.
- AVI with VIC=16 and correct checksum → vic=16 at t+6, infoframe_missing[1]=0. The same packet with a corrupted PB0 → vic unchanged, drop_count +1.
- No SPD for two video_field_end pulses → infoframe_missing[2]=1. SPD commit in the same cycle as video_field_end → bit cleared.
- packet_valid at t and again at t+2 → second packet dropped, drop_count=1, first packet fully processed.

Source files
------------

// File: rtl/hdmi_rx_pkg.sv
// Shared types for the HDMI receive data-island path: packet type codes,
// demux FSM states, the stereo sample word and the InfoFrame checksum helper.
package hdmi_rx_pkg;

  localparam logic [7:0] PKT_NULL  = 8'h00;
  localparam logic [7:0] PKT_ACR   = 8'h01;
  localparam logic [7:0] PKT_AUDIO = 8'h02;
  localparam logic [7:0] PKT_AVI   = 8'h82;
  localparam logic [7:0] PKT_SPD   = 8'h83;
  localparam logic [7:0] PKT_AIF   = 8'h84;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DECODE,
    ST_AUDIO,
    ST_CHECK,
    ST_COMMIT
  } demux_state_t;

  // Full 24-bit samples are stored; the top bits are taken at the output.
  typedef struct packed {
    logic [23:0] right;
    logic [23:0] left;
  } stereo_sample_t;

  // Sum of the payload bytes of subpacket j whose PB index is within the length.
  function automatic logic [7:0] subpacket_sum(input logic [55:0] sp,
                                               input logic [1:0]  j,
                                               input logic [4:0]  len);
    logic [7:0] s;
    s = 8'd0;
    for (int k = 0; k < 7; k++) begin
      if ((int'(j) * 7 + k) <= int'(len)) s = s + sp[8*k +: 8];
    end
    return s;
  endfunction

endpackage

// File: rtl/audio_sample_fifo.sv
// First-word-fall-through FIFO of stereo samples; a push into a full FIFO
// succeeds when a pop happens in the same cycle.
module audio_sample_fifo
  import hdmi_rx_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic           clk_pixel,
  input  logic           reset,
  input  logic           push,
  input  logic           pop,
  input  stereo_sample_t push_data,
  output stereo_sample_t head,
  output logic           empty,
  output logic           full
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  stereo_sample_t   mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_next;
  logic             do_push;
  logic             do_pop;

  assign do_pop     = pop && !empty;
  assign do_push    = push && (!full || do_pop);
  assign count_next = count + CNT_W'(do_push) - CNT_W'(do_pop);
  assign head       = mem[rd_ptr];

  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      empty  <= 1'b1;
      full   <= 1'b0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count_next;
      empty <= (count_next == '0);
      full  <= (count_next == CNT_W'(DEPTH));
    end
  end

endmodule

// File: rtl/packet_demux.sv
// Dispatches received data-island packets: audio samples to a FIFO, ACR and
// InfoFrame fields to registers. Define PACKET_DEMUX_CHECKSUM_EN to verify InfoFrame checksums.
module packet_demux
  import hdmi_rx_pkg::*;
#(
  parameter int unsigned AUDIO_BIT_WIDTH = 16,
  parameter int unsigned FIFO_DEPTH      = 8
) (
  input  logic                            clk_pixel,
  input  logic                            reset,
  input  logic                            packet_valid,
  input  logic                            packet_error,
  input  logic [23:0]                     header,
  input  logic [3:0][55:0]                sub,
  input  logic                            video_field_end,
  output logic                            audio_valid,
  input  logic                            audio_ready,
  output logic [1:0][AUDIO_BIT_WIDTH-1:0] audio_sample_word,
  output logic [19:0]                     acr_n,
  output logic [19:0]                     acr_cts,
  output logic                            acr_update,
  output logic [6:0]                      vic,
  output logic [2:0]                      infoframe_missing,
  output logic                            audio_overflow,
  output logic [7:0]                      drop_count
);

  localparam logic [2:0][7:0] IF_TYPES = {PKT_SPD, PKT_AVI, PKT_AIF};

  demux_state_t     state;
  logic [23:0]      hdr_q;
  logic [3:0][55:0] sub_q;
  logic [1:0]       idx;
  logic [2:0][1:0]  field_cnt;
  logic [7:0]       hb0;
  logic             push_c;
  logic             overflow_c;
  logic             decode_drop_c;
  logic             csum_fail_c;
  logic             csum_ok_c;
  logic [1:0]       drop_inc_c;
  logic [8:0]       drop_sum_c;
  logic             fifo_empty;
  logic             fifo_full;
  stereo_sample_t   head;
  logic             unused_bits;

  assign hb0 = hdr_q[7:0];

`ifdef PACKET_DEMUX_CHECKSUM_EN
  logic [7:0] csum;
  logic [7:0] csum_next_c;
  assign csum_next_c = csum + subpacket_sum(sub_q[idx], idx, hdr_q[20:16]);
  assign csum_ok_c   = (csum_next_c == 8'd0);
  assign csum_fail_c = (state == ST_CHECK) && (idx == 2'd3) && !csum_ok_c;
`else
  assign csum_ok_c   = 1'b1;
  assign csum_fail_c = 1'b0;
`endif

  // Drop sources: busy/errored arrival, audio layout 1, checksum failure.
  assign decode_drop_c = ((state == ST_DECODE) && (hb0 == PKT_AUDIO) && hdr_q[12]) || csum_fail_c;
  assign drop_inc_c    = 2'(packet_valid && ((state != ST_IDLE) || packet_error)) + 2'(decode_drop_c);
  assign drop_sum_c    = 9'(drop_count) + 9'(drop_inc_c);

  assign push_c     = (state == ST_AUDIO) && hdr_q[8 + 32'(idx)];
  assign overflow_c = push_c && fifo_full && !audio_ready;

  audio_sample_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk_pixel(clk_pixel),
    .reset    (reset),
    .push     (push_c),
    .pop      (audio_ready),
    .push_data(stereo_sample_t'(sub_q[idx][47:0])),
    .head     (head),
    .empty    (fifo_empty),
    .full     (fifo_full)
  );

  assign audio_valid          = !fifo_empty;
  assign audio_sample_word[0] = head.left[23 -: AUDIO_BIT_WIDTH];
  assign audio_sample_word[1] = head.right[23 -: AUDIO_BIT_WIDTH];
  assign infoframe_missing    = {field_cnt[2][1], field_cnt[1][1], field_cnt[0][1]};
  assign unused_bits          = ^{hdr_q, sub_q, head, csum_ok_c};

  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      state          <= ST_IDLE;
      hdr_q          <= '0;
      sub_q          <= '0;
      idx            <= '0;
      acr_n          <= '0;
      acr_cts        <= '0;
      acr_update     <= 1'b0;
      vic            <= '0;
      audio_overflow <= 1'b0;
      drop_count     <= '0;
`ifdef PACKET_DEMUX_CHECKSUM_EN
      csum           <= '0;
`endif
    end else begin
      acr_update <= 1'b0;
      drop_count <= drop_sum_c[8] ? 8'hFF : drop_sum_c[7:0];
      if (overflow_c) audio_overflow <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (packet_valid && !packet_error) begin
            hdr_q <= header;
            sub_q <= sub;
            state <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          idx <= 2'd0;
          case (hb0)
            PKT_NULL: state <= ST_IDLE;
            PKT_ACR: begin
              acr_cts    <= {sub_q[0][11:8], sub_q[0][23:16], sub_q[0][31:24]};
              acr_n      <= {sub_q[0][35:32], sub_q[0][47:40], sub_q[0][55:48]};
              acr_update <= 1'b1;
              state      <= ST_IDLE;
            end
            PKT_AUDIO: state <= hdr_q[12] ? ST_IDLE : ST_AUDIO;
            PKT_AVI, PKT_SPD, PKT_AIF: begin
`ifdef PACKET_DEMUX_CHECKSUM_EN
              csum  <= hdr_q[7:0] + hdr_q[15:8] + hdr_q[23:16];
              state <= ST_CHECK;
`else
              state <= ST_COMMIT;
`endif
            end
            default: state <= ST_IDLE;
          endcase
        end
        ST_AUDIO: begin
          idx <= idx + 2'd1;
          if (idx == 2'd3) state <= ST_IDLE;
        end
`ifdef PACKET_DEMUX_CHECKSUM_EN
        ST_CHECK: begin
          csum <= csum_next_c;
          idx  <= idx + 2'd1;
          if (idx == 2'd3) state <= csum_ok_c ? ST_COMMIT : ST_IDLE;
        end
`endif
        ST_COMMIT: begin
          if (hb0 == PKT_AVI) vic <= sub_q[0][38:32];
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Per-type field counters; a commit clear beats a simultaneous field end.
  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      field_cnt <= {3{2'd2}};
    end else begin
      for (int k = 0; k < 3; k++) begin
        if ((state == ST_COMMIT) && (hb0 == IF_TYPES[k])) field_cnt[k] <= 2'd0;
        else if (video_field_end && (field_cnt[k] != 2'd3)) field_cnt[k] <= field_cnt[k] + 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_packet_demux.sv
// Randomized bench for packet_demux with a transaction-level reference model
// (accept time + per-type latency, queue-based FIFO) and directed literal checks.
module tb_packet_demux;

  localparam int TB_W     = 16;
  localparam int TB_DEPTH = 4;
`ifdef PACKET_DEMUX_CHECKSUM_EN
  localparam bit CSUM = 1'b1;
`else
  localparam bit CSUM = 1'b0;
`endif

  logic                 clk_pixel = 1'b0;
  logic                 reset = 1'b1;
  logic                 packet_valid = 1'b0;
  logic                 packet_error = 1'b0;
  logic [23:0]          header = '0;
  logic [3:0][55:0]     sub = '0;
  logic                 video_field_end = 1'b0;
  logic                 audio_valid;
  logic                 audio_ready = 1'b0;
  logic [1:0][TB_W-1:0] audio_sample_word;
  logic [19:0]          acr_n;
  logic [19:0]          acr_cts;
  logic                 acr_update;
  logic [6:0]           vic;
  logic [2:0]           infoframe_missing;
  logic                 audio_overflow;
  logic [7:0]           drop_count;

  packet_demux #(.AUDIO_BIT_WIDTH(TB_W), .FIFO_DEPTH(TB_DEPTH)) dut (
    .clk_pixel(clk_pixel), .reset(reset), .packet_valid(packet_valid),
    .packet_error(packet_error), .header(header), .sub(sub),
    .video_field_end(video_field_end), .audio_valid(audio_valid),
    .audio_ready(audio_ready), .audio_sample_word(audio_sample_word),
    .acr_n(acr_n), .acr_cts(acr_cts), .acr_update(acr_update), .vic(vic),
    .infoframe_missing(infoframe_missing), .audio_overflow(audio_overflow),
    .drop_count(drop_count)
  );

  always #5 clk_pixel = ~clk_pixel;

  int n_tests = 0;
  int n_fail  = 0;
  bit rand_bg = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // InfoFrame byte sum: header bytes plus PB0..PB[len], PB p in subpacket p/7 byte p%7.
  function automatic logic [7:0] if_sum(input logic [23:0] h, input logic [3:0][55:0] s);
    logic [7:0] acc;
    int len;
    acc = h[7:0] + h[15:8] + h[23:16];
    len = int'(h[20:16]);
    for (int p = 0; p <= len && p < 28; p++) acc = acc + s[p/7][8*(p%7) +: 8];
    return acc;
  endfunction

  function automatic bit is_if(input logic [7:0] t);
    return (t == 8'h82) || (t == 8'h83) || (t == 8'h84);
  endfunction

  // Cycles the block stays busy after accepting a packet.
  function automatic int busy_len(input logic [23:0] h, input logic [3:0][55:0] s);
    if (h[7:0] == 8'h02) return h[12] ? 2 : 6;
    if (is_if(h[7:0])) begin
      if (!CSUM) return 3;
      return (if_sum(h, s) == 8'd0) ? 7 : 6;
    end
    return 2;
  endfunction

  // ---------------- reference model ----------------
  bit               model_ok = 1'b0;
  int               edge_n = 0;
  int               free_at = 0;
  bit               pend = 1'b0;
  int               pacc = 0;
  logic [23:0]      ph;
  logic [3:0][55:0] ps;
  logic [31:0]      q[$];
  logic [19:0]      e_acr_n, e_acr_cts;
  logic             e_acr_update, e_ovf;
  logic [6:0]       e_vic;
  int               e_drop;
  int               cnt[3];

  always @(posedge clk_pixel) begin
    int off, inc, clr_k;
    if (reset) begin
      model_ok = 1'b1; pend = 1'b0; free_at = 0; q.delete();
      e_acr_n = '0; e_acr_cts = '0; e_acr_update = 1'b0; e_ovf = 1'b0;
      e_vic = '0; e_drop = 0;
      for (int k = 0; k < 3; k++) cnt[k] = 2;
    end else if (model_ok) begin
      inc = 0; clr_k = -1; e_acr_update = 1'b0;
      if (audio_ready && q.size() > 0) void'(q.pop_front());
      if (pend) begin
        off = edge_n - pacc;
        if (ph[7:0] == 8'h01) begin
          e_acr_cts = {ps[0][11:8], ps[0][23:16], ps[0][31:24]};
          e_acr_n   = {ps[0][35:32], ps[0][47:40], ps[0][55:48]};
          e_acr_update = 1'b1; pend = 1'b0;
        end else if (ph[7:0] == 8'h02) begin
          if (ph[12]) begin inc++; pend = 1'b0; end
          else if (off >= 2 && off <= 5) begin
            if (ph[8 + off - 2]) begin
              if (q.size() < TB_DEPTH) q.push_back({ps[off-2][47 -: TB_W], ps[off-2][23 -: TB_W]});
              else e_ovf = 1'b1;
            end
            if (off == 5) pend = 1'b0;
          end
        end else if (is_if(ph[7:0])) begin
          if (CSUM && off == 5 && if_sum(ph, ps) != 8'd0) begin inc++; pend = 1'b0; end
          else if (off == (CSUM ? 6 : 2)) begin
            if (ph[7:0] == 8'h82) e_vic = ps[0][38:32];
            clr_k = (ph[7:0] == 8'h84) ? 0 : (ph[7:0] == 8'h82) ? 1 : 2;
            pend = 1'b0;
          end
        end else pend = 1'b0;
      end
      for (int k = 0; k < 3; k++) begin
        if (k == clr_k) cnt[k] = 0;
        else if (video_field_end && cnt[k] < 3) cnt[k]++;
      end
      if (packet_valid) begin
        if (edge_n < free_at || packet_error) inc++;
        else begin
          pend = 1'b1; pacc = edge_n; ph = header; ps = sub;
          free_at = edge_n + busy_len(header, sub);
        end
      end
      e_drop = (e_drop + inc > 255) ? 255 : e_drop + inc;
    end
    edge_n++;
  end

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk_pixel) begin
    if (model_ok) begin
      chk("audio_valid", 32'(audio_valid), 32'(q.size() > 0));
      if (q.size() > 0) chk("audio_word", {audio_sample_word[1], audio_sample_word[0]}, q[0]);
      chk("acr_n", 32'(acr_n), 32'(e_acr_n));
      chk("acr_cts", 32'(acr_cts), 32'(e_acr_cts));
      chk("acr_update", 32'(acr_update), 32'(e_acr_update));
      chk("vic", 32'(vic), 32'(e_vic));
      chk("infoframe_missing", 32'(infoframe_missing),
          {29'd0, cnt[2] >= 2, cnt[1] >= 2, cnt[0] >= 2});
      chk("audio_overflow", 32'(audio_overflow), 32'(e_ovf));
      chk("drop_count", 32'(drop_count), 32'(e_drop));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk_pixel);
    #1;
    if (rand_bg) begin
      audio_ready     = ($urandom_range(0, 3) != 0);
      video_field_end = ($urandom_range(0, 19) == 0);
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    reset = 1'b1; ticks(2); reset = 1'b0;
  endtask

  task automatic send(input logic [23:0] h, input logic [3:0][55:0] s, input bit err);
    packet_valid = 1'b1; packet_error = err; header = h; sub = s;
    tick();
    packet_valid = 1'b0; packet_error = 1'b0;
  endtask

  task automatic rand_sub(output logic [3:0][55:0] s);
    for (int j = 0; j < 4; j++) s[j] = {24'($urandom), 32'($urandom)};
  endtask

  task automatic make_if(input logic [7:0] t, input logic [7:0] hb2, input logic [6:0] vicv,
                         input bit good, output logic [23:0] h, output logic [3:0][55:0] s);
    rand_sub(s);
    h = {hb2, 8'h02, t};
    if (t == 8'h82) s[0][39:32] = {1'b0, vicv};
    s[0][7:0] = 8'd0;
    s[0][7:0] = 8'(8'd0 - if_sum(h, s));
    if (!good) s[0][7:0] = s[0][7:0] + 8'h5A;
  endtask

  task automatic count_pops(input int n, output int got);
    got = 0;
    audio_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      if (audio_valid) begin
        got++;
        chk("pair_left", 32'(audio_sample_word[0]), 32'h1234);
        chk("pair_right", 32'(audio_sample_word[1]), 32'hABCD);
      end
      tick();
    end
  endtask

  logic [23:0]      h;
  logic [3:0][55:0] s;
  logic [3:0][55:0] aud_s;
  int               got;

  initial begin
    for (int j = 0; j < 4; j++) aud_s[j] = {8'h00, 24'hABCDEF, 24'h123456};
    do_reset();

    // Reset values
    chk("rst_audio_valid", 32'(audio_valid), 32'd0);
    chk("rst_word", {audio_sample_word[1], audio_sample_word[0]}, 32'd0);
    chk("rst_acr", {12'd0, acr_n ^ acr_cts}, 32'd0);
    chk("rst_acr_update", 32'(acr_update), 32'd0);
    chk("rst_vic", 32'(vic), 32'd0);
    chk("rst_missing", 32'(infoframe_missing), 32'd7);
    chk("rst_overflow", 32'(audio_overflow), 32'd0);
    chk("rst_drop", 32'(drop_count), 32'd0);

    // ACR: values and one-cycle update pulse two cycles after the strobe
    s = '0; s[0] = 56'h00180000180001;
    send(24'h000001, s, 1'b0);
    chk("acr_pulse_early", 32'(acr_update), 32'd0);
    tick();
    chk("acr_cts_lit", 32'(acr_cts), 32'h01800);
    chk("acr_n_lit", 32'(acr_n), 32'h01800);
    chk("acr_pulse", 32'(acr_update), 32'd1);
    tick();
    chk("acr_pulse_end", 32'(acr_update), 32'd0);

    // Audio: four pairs delivered on consecutive cycles
    audio_ready = 1'b1;
    send(24'h000F02, aud_s, 1'b0);
    count_pops(10, got);
    chk("audio_pairs", 32'(got), 32'd4);

    // AVI VIC=16, then a corrupted copy carrying VIC=5
    do_reset();
    make_if(8'h82, 8'h0D, 7'd16, 1'b1, h, s);
    send(h, s, 1'b0); ticks(8);
    chk("avi_vic", 32'(vic), 32'd16);
    chk("avi_present", 32'(infoframe_missing[1]), 32'd0);
    make_if(8'h82, 8'h0D, 7'd5, 1'b0, h, s);
    send(h, s, 1'b0); ticks(8);
    chk("avi_bad_vic", 32'(vic), CSUM ? 32'd16 : 32'd5);
    chk("avi_bad_drop", 32'(drop_count), CSUM ? 32'd1 : 32'd0);

    // SPD presence across field ends, and clear winning over a coincident field end
    make_if(8'h83, 8'h19, 7'd0, 1'b1, h, s);
    send(h, s, 1'b0); ticks(8);
    chk("spd_present", 32'(infoframe_missing[2]), 32'd0);
    video_field_end = 1'b1; tick(); video_field_end = 1'b0; tick();
    chk("spd_one_field", 32'(infoframe_missing[2]), 32'd0);
    video_field_end = 1'b1; tick(); video_field_end = 1'b0; tick();
    chk("spd_missing", 32'(infoframe_missing[2]), 32'd1);
    send(h, s, 1'b0);
    ticks(CSUM ? 5 : 1);
    video_field_end = 1'b1; tick(); video_field_end = 1'b0;
    chk("spd_clear_wins", 32'(infoframe_missing[2]), 32'd0);
    ticks(2);

    // Second packet two cycles after an audio packet is dropped
    do_reset();
    audio_ready = 1'b1;
    send(24'h000F02, aud_s, 1'b0);
    tick();
    s = '0; s[0] = 56'h00180000180001;
    send(24'h000001, s, 1'b0);
    count_pops(10, got);
    chk("collide_pairs", 32'(got), 32'd4);
    chk("collide_drop", 32'(drop_count), 32'd1);
    chk("collide_acr", 32'(acr_cts), 32'd0);

    // Overflow with a stalled consumer, then drain exactly the FIFO depth
    audio_ready = 1'b0;
    send(24'h000F02, aud_s, 1'b0); ticks(8);
    send(24'h000F02, aud_s, 1'b0); ticks(8);
    chk("ovf_flag", 32'(audio_overflow), 32'd1);
    chk("ovf_held", 32'(audio_valid), 32'd1);
    count_pops(10, got);
    chk("ovf_drain", 32'(got), 32'd4);

    // Randomized traffic
    rand_bg = 1'b1;
    for (int n = 0; n < 250; n++) begin
      int kind;
      kind = $urandom_range(0, 9);
      rand_sub(s);
      case (kind)
        0: h = {16'($urandom), 8'h00};
        1: h = {16'($urandom), 8'h01};
        2, 3: h = {8'($urandom), 3'd0, ($urandom_range(0, 3) == 0), 4'($urandom), 8'h02};
        4, 9: make_if(8'h82, 8'($urandom), 7'($urandom), 1'b1, h, s);
        5: make_if(8'h83, 8'($urandom), 7'd0, 1'b1, h, s);
        6: make_if(8'h84, 8'($urandom), 7'd0, 1'b1, h, s);
        7: make_if(8'h82 + 8'($urandom_range(0, 2)), 8'($urandom), 7'($urandom), 1'b0, h, s);
        default: h = {16'($urandom), ($urandom_range(0, 1) == 0) ? 8'h0A : 8'h81};
      endcase
      send(h, s, ($urandom_range(0, 15) == 0));
      ticks(($urandom_range(0, 3) == 0) ? $urandom_range(0, 6) : $urandom_range(6, 30));
    end
    rand_bg = 1'b0; video_field_end = 1'b0;

    // Reset mid-packet: nothing from the aborted AVI is committed
    make_if(8'h82, 8'h0D, 7'd99, 1'b1, h, s);
    send(h, s, 1'b0); tick();
    do_reset(); ticks(10);
    chk("abort_vic", 32'(vic), 32'd0);
    chk("abort_missing", 32'(infoframe_missing), 32'd7);

    // drop_count saturation
    for (int n = 0; n < 200; n++) send(24'h000001, s, 1'b1);
    chk("drop_200", 32'(drop_count), 32'd200);
    for (int n = 0; n < 60; n++) send(24'h000001, s, 1'b1);
    chk("drop_sat", 32'(drop_count), 32'd255);
    ticks(3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
